// File: rtl/decoder_addr_seq.sv
// Burst address sequencer for a 4-to-16 word-line decoder.
// Alternates precharge and access cycles, stepping the address between words.
module decoder_addr_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_addr,
   input  logic [3:0] req_len,
   input  logic       req_dir,
   input  logic       abort,
   output logic [3:0] a,
   output logic       wl_en,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRECH  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] rem_q, rem_d;
   logic       dir_q, dir_d;
   logic       wl_en_q, wl_en_d;
   logic       accept;
   logic       step;

   assign accept = req_valid & req_ready;
   assign step   = (state_q == ACCESS) && (state_d == PRECH);

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= 4'h0;
         rem_q   <= 4'h0;
         dir_q   <= 1'b0;
         wl_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         wl_en_q <= wl_en_d;
      end
   end

   // Next-state: abort in ACCESS still finishes the current word.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (accept) state_d = PRECH;
         PRECH:  state_d = abort ? DONE : ACCESS;
         ACCESS: state_d = (abort || rem_q == 4'd0) ? DONE : PRECH;
         DONE:   state_d = IDLE;
      endcase
   end

   // Datapath: address only moves on the edge into PRECH.
   always_comb begin
      a_d   = a_q;
      rem_d = rem_q;
      dir_d = dir_q;
      if (accept) begin
         a_d   = req_addr;
         rem_d = req_len;
         dir_d = req_dir;
      end else if (step) begin
         rem_d = rem_q - 4'd1;
         a_d   = dir_q ? (a_q - 4'd1) : (a_q + 4'd1);
      end
   end

   // Outputs: wl_en is registered so it lines up with ACCESS.
   always_comb begin
      wl_en_d   = (state_d == ACCESS);
      req_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

   assign a     = a_q;
   assign wl_en = wl_en_q;

endmodule

// File: tb/tb_decoder_addr_seq.sv
// Scoreboard bench for decoder_addr_seq.
// Driver queues expected word accesses and done pulses; monitor consumes them.
module tb_decoder_addr_seq;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_addr;
   logic [3:0] req_len;
   logic       req_dir;
   logic       abort;
   logic [3:0] a;
   logic       wl_en;
   logic       busy;
   logic       done;

   typedef struct {
      bit         is_done;
      logic [3:0] addr;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   busq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   bcnt = 0;
   bit   prev_busy = 0;

   decoder_addr_seq dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_dir   (req_dir),
      .abort     (abort),
      .a         (a),
      .wl_en     (wl_en),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   // Monitor: consume expectations whenever the DUT shows a word or a done.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         bcnt = 0;
         prev_busy = 0;
      end else begin
         if (wl_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_wl_en cyc=%0d a=%0d", cyc, a);
            end else begin
               e = exp_q.pop_front();
               if (e.is_done || e.addr != a || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL access act a=%0d cyc=%0d exp done=%0b a=%0d cyc=%0d",
                           a, cyc, e.is_done, e.addr, e.cyc);
               end
            end
         end
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
               e = exp_q.pop_front();
               if (!e.is_done || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL done act cyc=%0d exp done=%0b cyc=%0d",
                           cyc, e.is_done, e.cyc);
               end
            end
         end
         checks++;
         if (req_ready == busy || (req_ready && (done || wl_en))) begin
            errors++;
            $display("FAIL exclusive ready=%0b busy=%0b done=%0b wl_en=%0b",
                     req_ready, busy, done, wl_en);
         end
         if (busy) bcnt++;
         else if (prev_busy) begin
            checks++;
            if (busq.size() == 0) begin
               errors++;
               $display("FAIL busy_len act=%0d exp=none", bcnt);
            end else begin
               int eb;
               eb = busq.pop_front();
               if (eb != bcnt) begin
                  errors++;
                  $display("FAIL busy_len act=%0d exp=%0d", bcnt, eb);
               end
            end
            bcnt = 0;
         end
         prev_busy = busy;
      end
   end

   // Issue one burst from a negedge; returns at the negedge of cycle T+1.
   task automatic run_burst(input logic [3:0] ad, input logic [3:0] ln,
                            input logic dr, input int ab_acc,
                            input int ab_pre, input bit hold,
                            output int base);
      int         n;
      int         nw;
      int         dc;
      logic [3:0] x;
      exp_t       e;
      base = -1;
      req_addr = ad;
      req_len = ln;
      req_dir = dr;
      req_valid = 1'b1;
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      base = cyc;
      n = int'(ln) + 1;
      if (ab_pre > 0) begin
         nw = ab_pre - 1;
         dc = base + 2 * ab_pre;
      end else if (ab_acc > 0) begin
         nw = ab_acc;
         dc = base + 2 * ab_acc + 1;
      end else begin
         nw = n;
         dc = base + 2 * n + 1;
      end
      x = ad;
      for (int k = 1; k <= nw; k++) begin
         e.is_done = 0;
         e.addr = x;
         e.cyc = base + 2 * k;
         exp_q.push_back(e);
         x = dr ? x - 4'd1 : x + 4'd1;
      end
      e.is_done = 1;
      e.addr = 4'd0;
      e.cyc = dc;
      exp_q.push_back(e);
      busq.push_back(dc - base);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (ab_acc > 0 || ab_pre > 0) begin
         int at;
         at = (ab_pre > 0) ? base + 2 * ab_pre - 1 : base + 2 * ab_acc;
         while (cyc < at) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && req_ready) break;
      end
      if (i == 200) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      int b1;
      int b2;
      reset = 1'b1;
      req_valid = 1'b0;
      req_addr = 4'h0;
      req_len = 4'h0;
      req_dir = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_a", int'(a), 0);
      chk("rst_wl_en", int'(wl_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);

      // Single word right after reset release.
      reset = 1'b0;
      run_burst(4'd5, 4'd0, 1'b0, 0, 0, 0, b1);
      chk("single_base", b1, cyc - 1);
      chk("single_a_t1", int'(a), 5);
      chk("single_wl_t1", int'(wl_en), 0);
      chk("single_busy_t1", int'(busy), 1);
      wait_idle();
      chk("single_hold_a", int'(a), 5);
      chk("single_idle_wl", int'(wl_en), 0);

      run_burst(4'd14, 4'd3, 1'b0, 0, 0, 0, b1);
      wait_idle();
      chk("inc_wrap_last_a", int'(a), 1);

      run_burst(4'd1, 4'd2, 1'b1, 0, 0, 0, b1);
      wait_idle();
      chk("dec_wrap_last_a", int'(a), 15);

      run_burst(4'd0, 4'd15, 1'b0, 0, 0, 0, b1);
      wait_idle();

      run_burst(4'd3, 4'd7, 1'b0, 3, 0, 0, b1);
      wait_idle();

      run_burst(4'd8, 4'd7, 1'b0, 0, 2, 0, b1);
      wait_idle();

      // Abort while idle has no effect.
      abort = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_abort_busy", int'(busy), 0);
      chk("idle_abort_ready", int'(req_ready), 1);
      abort = 1'b0;

      // Request held through a burst: next accept one idle cycle after done.
      run_burst(4'd2, 4'd1, 1'b0, 0, 0, 1, b1);
      run_burst(4'd7, 4'd0, 1'b1, 0, 0, 0, b2);
      chk("b2b_gap", b2, b1 + 6);
      wait_idle();

      // Asynchronous reset in the middle of the second access.
      run_burst(4'd9, 4'd7, 1'b0, 0, 0, 0, b1);
      while (cyc < b1 + 4) @(negedge clk);
      chk("mid_wl_before", int'(wl_en), 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_wl_en", int'(wl_en), 0);
      chk("mid_rst_a", int'(a), 0);
      chk("mid_rst_ready", int'(req_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      exp_q.delete();
      busq.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      run_burst(4'd10, 4'd1, 1'b1, 0, 0, 0, b1);
      wait_idle();
      chk("post_rst_last_a", int'(a), 9);

      repeat (3) @(negedge clk);
      chk("drain_exp", exp_q.size(), 0);
      chk("drain_busy", busq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_addr_seq.md
DECODER_ADDR_SEQ -- requirements
Module: decoder_addr_seq

Interface
REQ-001 The block SHALL have one clock and one reset. Reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  burst request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  4  burst start address.
REQ-007 req_len  input  4  burst length minus one (0..15 means 1..16 words).
REQ-008 req_dir  input  1  address step: 0 = increment, 1 = decrement.
REQ-009 abort  input  1  terminate the current burst early.
REQ-010 a  output  4  registered address to the 4-to-16 word-line decoder.
REQ-011 wl_en  output  1  registered word-line enable that qualifies the decoded lines.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at burst end.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, PRECH, ACCESS and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted only when req_valid and req_ready are both 1 at a rising edge.
REQ-016 On accept the block SHALL:
- latch req_addr into a;
- latch req_len into a 4-bit remaining counter;
- latch req_dir;
- move to PRECH.
REQ-017 In PRECH, wl_en SHALL be 0; the next state SHALL be ACCESS.
REQ-018 In ACCESS, wl_en SHALL be 1 and a SHALL be stable.
REQ-019 Leaving ACCESS when remaining = 0 SHALL go to DONE.
REQ-020 Leaving ACCESS when remaining > 0 SHALL go to PRECH, decrement remaining, and step a by +1 (req_dir=0) or -1 (req_dir=1).
REQ-021 The address step SHALL be modulo 16: 15+1 wraps to 0, and 0-1 wraps to 15.
REQ-022 a SHALL change only on the edge into PRECH, so it never changes while wl_en=1 (glitch-free decoder outputs).
REQ-023 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-024 Burst timing for N = req_len+1 words, with the request accepted at edge T:
- the k-th ACCESS (k=1..N) SHALL occupy cycle T+2k;
- done SHALL be high in cycle T+2N+1;
- req_ready SHALL return in cycle T+2N+2;
- busy SHALL be high for 2N+1 cycles.
REQ-025 abort sampled high in PRECH SHALL go to DONE without asserting wl_en for that word.
REQ-026 abort sampled high in ACCESS SHALL complete the current access cycle, then go to DONE, ignoring remaining.
REQ-027 abort SHALL be ignored in IDLE and in DONE.
REQ-028 A request presented while busy SHALL NOT be accepted and SHALL NOT disturb the burst in progress; the requester holds req_valid.
REQ-029 req_valid high during DONE SHALL be accepted only in the following IDLE cycle, so back-to-back bursts are separated by exactly one IDLE cycle.
REQ-030 In IDLE, a SHALL hold the last burst address, and wl_en SHALL be 0.
REQ-031 done, wl_en and busy SHALL never be high in the same cycle as req_ready, except that busy and wl_en may be high together.

Reset
REQ-032 While reset=1 the block SHALL hold, independent of clk:
- state = IDLE;
- a = 4'h0;
- remaining = 0;
- stored direction = 0;
- wl_en = 0, done = 0, busy = 0;
- req_ready = 1.
REQ-033 Reset asserted mid-burst SHALL immediately force wl_en=0 and the REQ-032 values; no done pulse SHALL be produced for the aborted burst.
REQ-034 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 Single word: req_addr=5, req_len=0, req_dir=0, accepted at T -> a=5 in T+1 with wl_en=0; wl_en=1 in T+2; done in T+3; req_ready=1 in T+4.
REQ-036 Increment wrap: req_addr=14, req_len=3, req_dir=0 -> ACCESS addresses 14, 15, 0, 1; done in T+9; a=1 after the burst.
REQ-037 Decrement wrap: req_addr=1, req_len=2, req_dir=1 -> ACCESS addresses 1, 0, 15.
REQ-038 Full burst: req_addr=0, req_len=15, req_dir=0 -> 16 wl_en pulses, each exactly one cycle and separated by a wl_en=0 cycle; busy high 33 cycles; a never changes while wl_en=1.
REQ-039 Abort: len=7 burst with abort pulsed in the 3rd ACCESS -> exactly 3 wl_en pulses, then done the next cycle.
REQ-040 Abort in PRECH: len=7 burst with abort in the 2nd PRECH -> exactly 1 wl_en pulse, then done.
REQ-041 Reset mid-burst: reset asserted asynchronously between edges in ACCESS -> wl_en=0, a=0 and req_ready=1 immediately; no done pulse.
REQ-042 Request while busy: req_valid held through a burst -> second burst accepted exactly one IDLE cycle after done.
